// File: rtl/neopixel_frame_scheduler.sv
// neopixel_frame_scheduler
// Double-buffered WS2812 frame controller. Host writes always land in the back
// buffer. Buffers swap only at a frame start, so a displayed frame is never torn.
// The active buffer is streamed one pixel at a time through the serializer's
// valid/busy handshake. A latch gap follows the last pixel, and frames are paced
// at a fixed start-to-start period.
//
// Ports:
//   CLK, RESETN            clock, synchronous active-low reset
//   i_enable               run frames; a running frame always completes
//   i_wr_en/addr/data      back-buffer pixel write ({R,G,B}); addr >= NUM_PIXELS ignored
//   i_commit               request buffer swap at next frame start
//   i_px_busy              serializer busy
//   o_px_valid             one-cycle pixel strobe
//   o_px_r/g/b, o_px_index pixel presented with the strobe (held between strobes)
//   o_active_buf           buffer being displayed
//   o_frame_start/done     one-cycle pulses at frame start / end of latch gap
//   o_err                  sticky serializer ack timeout
module neopixel_frame_scheduler #(
    parameter int unsigned NUM_PIXELS   = 10,
    parameter int unsigned AW           = 4,
    parameter int unsigned LATCH_CYCLES = 3600,
    parameter int unsigned FRAME_CYCLES = 200000,
    parameter int unsigned ACK_TIMEOUT  = 8
) (
    input  logic          CLK,
    input  logic          RESETN,
    input  logic          i_enable,
    input  logic          i_wr_en,
    input  logic [AW-1:0] i_wr_addr,
    input  logic [23:0]   i_wr_data,
    input  logic          i_commit,
    input  logic          i_px_busy,
    output logic          o_px_valid,
    output logic [7:0]    o_px_r,
    output logic [7:0]    o_px_g,
    output logic [7:0]    o_px_b,
    output logic [AW-1:0] o_px_index,
    output logic          o_active_buf,
    output logic          o_frame_start,
    output logic          o_frame_done,
    output logic          o_err
);

    localparam int unsigned PW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam int unsigned LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam int unsigned KW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [PW-1:0] PER_LAST = PW'(FRAME_CYCLES - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYCLES - 1);
    localparam logic [KW-1:0] ACK_LAST = KW'(ACK_TIMEOUT - 1);
    localparam logic [AW-1:0] IDX_LAST = AW'(NUM_PIXELS - 1);
    localparam logic [AW:0]   NPIX     = (AW+1)'(NUM_PIXELS);

    typedef enum logic [2:0] {
        IDLE, START, LOAD, STROBE, WAIT_ACK, WAIT_DONE, LATCH, GAP
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [KW-1:0] ack_q, ack_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [PW-1:0] per_q, per_d;
    logic          active_q, active_d;
    logic          pend_q, pend_d;
    logic          valid_q, valid_d;
    logic [23:0]   px_q, px_d;
    logic [AW-1:0] pidx_q, pidx_d;
    logic          start_q, start_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          pixel_done;

    // Pixel RAM: two buffers, not reset. The read is registered (one-cycle latency).
    logic [23:0] pix_mem [2][2**AW];
    logic [23:0] rd_q;

    always_ff @(posedge CLK) begin
        // active_q is the pre-swap value, so a write in the swap cycle hits the old back buffer
        if (i_wr_en && ({1'b0, i_wr_addr} < NPIX)) begin
            pix_mem[~active_q][i_wr_addr] <= i_wr_data;
        end
        if (state_q == LOAD) begin
            rd_q <= pix_mem[active_q][idx_q];
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ack_d      = ack_q;
        lat_d      = lat_q;
        active_d   = active_q;
        pend_d     = pend_q | i_commit;
        valid_d    = 1'b0;
        px_d       = px_q;
        pidx_d     = pidx_q;
        done_d     = 1'b0;
        err_d      = err_q;
        pixel_done = 1'b0;

        unique case (state_q)
            IDLE: if (i_enable) state_d = START;
            START: begin
                if (pend_q) begin
                    active_d = ~active_q;
                    pend_d   = i_commit;
                end
                idx_d   = '0;
                state_d = LOAD;
            end
            LOAD: state_d = STROBE;
            STROBE: begin
                if (!i_px_busy) begin
                    valid_d = 1'b1;
                    px_d    = rd_q;
                    pidx_d  = idx_q;
                    ack_d   = '0;
                    state_d = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (i_px_busy) begin
                    state_d = WAIT_DONE;
                end else if (ack_q == ACK_LAST) begin
                    err_d      = 1'b1;
                    pixel_done = 1'b1;
                end else begin
                    ack_d = ack_q + 1'b1;
                end
            end
            WAIT_DONE: if (!i_px_busy) pixel_done = 1'b1;
            LATCH: begin
                if (lat_q == LAT_LAST) begin
                    done_d  = 1'b1;
                    state_d = GAP;
                end else begin
                    lat_d = lat_q + 1'b1;
                end
            end
            GAP: begin
                if (!i_enable) state_d = IDLE;
                else if (per_q >= PER_LAST) state_d = START;
            end
            default: state_d = IDLE;
        endcase

        // Both a normal ack and a timeout retire the pixel here
        if (pixel_done) begin
            if (idx_q == IDX_LAST) begin
                lat_d   = '0;
                state_d = LATCH;
            end else begin
                idx_d   = idx_q + 1'b1;
                state_d = LOAD;
            end
        end

        // Counter reads 0 during the START cycle, so START-to-START is exactly FRAME_CYCLES
        per_d   = (state_d == START) ? '0 : ((per_q == PER_LAST) ? per_q : per_q + 1'b1);
        start_d = (state_d == START);
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            ack_q    <= '0;
            lat_q    <= '0;
            per_q    <= '0;
            active_q <= 1'b0;
            pend_q   <= 1'b0;
            valid_q  <= 1'b0;
            px_q     <= '0;
            pidx_q   <= '0;
            start_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            ack_q    <= ack_d;
            lat_q    <= lat_d;
            per_q    <= per_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            valid_q  <= valid_d;
            px_q     <= px_d;
            pidx_q   <= pidx_d;
            start_q  <= start_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign o_px_valid    = valid_q;
    assign o_px_r        = px_q[23:16];
    assign o_px_g        = px_q[15:8];
    assign o_px_b        = px_q[7:0];
    assign o_px_index    = pidx_q;
    assign o_active_buf  = active_q;
    assign o_frame_start = start_q;
    assign o_frame_done  = done_q;
    assign o_err         = err_q;

endmodule

// File: tb/tb_neopixel_frame_scheduler.sv
module tb_neopixel_frame_scheduler;

    localparam int N   = 10;
    localparam int LAT = 20;
    localparam int FRM = 600;
    localparam int ACK = 8;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic        i_enable = 1'b0;
    logic        i_wr_en = 1'b0;
    logic [3:0]  i_wr_addr = '0;
    logic [23:0] i_wr_data = '0;
    logic        i_commit = 1'b0;
    logic        i_px_busy = 1'b0;
    logic        o_px_valid;
    logic [7:0]  o_px_r, o_px_g, o_px_b;
    logic [3:0]  o_px_index;
    logic        o_active_buf, o_frame_start, o_frame_done, o_err;

    neopixel_frame_scheduler #(
        .NUM_PIXELS(N), .AW(4), .LATCH_CYCLES(LAT), .FRAME_CYCLES(FRM), .ACK_TIMEOUT(ACK)
    ) dut (
        .CLK(CLK), .RESETN(RESETN), .i_enable(i_enable), .i_wr_en(i_wr_en),
        .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data), .i_commit(i_commit),
        .i_px_busy(i_px_busy), .o_px_valid(o_px_valid), .o_px_r(o_px_r),
        .o_px_g(o_px_g), .o_px_b(o_px_b), .o_px_index(o_px_index),
        .o_active_buf(o_active_buf), .o_frame_start(o_frame_start),
        .o_frame_done(o_frame_done), .o_err(o_err)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    task automatic tmo(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected event (cycle %0d)", nm, cyc);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Serializer stand-in: busy rises 2 clocks after a strobe and stays up busy_len clocks
    logic ser_mode = 1'b1;
    int   busy_len = 30;
    initial forever begin
        @(negedge CLK);
        if (o_px_valid && ser_mode) begin
            tick();
            @(posedge CLK); #1;
            i_px_busy = 1'b1;
            repeat (busy_len) @(posedge CLK);
            #1;
            i_px_busy = 1'b0;
        end
    end

    // Reference model: frame-level rules expressed as buffers, counts and event times
    logic [23:0] m_buf [2][N];
    logic        m_active = 1'b0, m_pend = 1'b0, m_err = 1'b0;
    int          scount = 0;
    logic        vprev = 1'b0;
    logic        ack_wait = 1'b0;
    int          ack_v = 0;
    logic        last_wait = 1'b0, last_seen = 1'b0;
    int          last_v = 0;
    int          done_at = -1;
    int          prev_start = -1;
    int          pace_exp = -1;
    logic        en_ok = 1'b0;
    logic        exp_zero = 1'b0;
    logic [23:0] cap [N];
    int          last_cnt = 0;
    int          nstarts = 0;

    always @(negedge CLK) begin
        logic pre;
        if (exp_zero)
            chk("reset_outputs", {o_px_valid, o_px_r, o_px_g, o_px_b, o_px_index,
                                  o_active_buf, o_frame_start, o_frame_done, o_err}, '0);
        chk("active_buf", o_active_buf, m_active);
        chk("err", o_err, m_err);
        chk("frame_done", o_frame_done, cyc == done_at);
        if (pace_exp >= 0 && en_ok)
            chk("frame_start_pace", o_frame_start, cyc == pace_exp);
        if (o_px_valid) begin
            chk("valid_single_cycle", vprev, 1'b0);
            chk("px_index", o_px_index, scount);
            if (scount < N) begin
                chk("px_data", {o_px_r, o_px_g, o_px_b}, m_buf[m_active][scount]);
                cap[scount] = {o_px_r, o_px_g, o_px_b};
            end
        end
        if (o_frame_done) begin
            chk("strobes_per_frame", scount, N);
            last_cnt = scount;
        end

        pre = m_active;
        if (i_wr_en && i_wr_addr < N) m_buf[!pre][i_wr_addr] = i_wr_data;
        if (!RESETN) begin
            exp_zero = 1'b1;
            m_active = 1'b0; m_pend = 1'b0; m_err = 1'b0;
            scount = 0; ack_wait = 1'b0; last_wait = 1'b0;
            done_at = -1; prev_start = -1; pace_exp = -1;
        end else begin
            exp_zero = 1'b0;
            if (o_frame_start) begin
                if (m_pend) begin
                    m_active = !m_active;
                    m_pend = 1'b0;
                end
                scount = 0;
                prev_start = cyc;
                pace_exp = -1;
                nstarts++;
            end
            if (i_commit) m_pend = 1'b1;
            if (o_px_valid) begin
                scount++;
                ack_wait = 1'b1;
                ack_v = cyc;
                if (scount == N) begin
                    last_wait = 1'b1; last_seen = 1'b0; last_v = cyc;
                end
            end
            if (ack_wait) begin
                if (i_px_busy) ack_wait = 1'b0;
                else if (cyc == ack_v + ACK - 1) begin
                    m_err = 1'b1;
                    ack_wait = 1'b0;
                end
            end
            if (last_wait) begin
                if (i_px_busy) last_seen = 1'b1;
                else if (last_seen || cyc == last_v + ACK - 1) begin
                    done_at = cyc + LAT + 1;
                    last_wait = 1'b0;
                end
            end
            if (o_frame_done && prev_start >= 0) begin
                pace_exp = (prev_start + FRM > cyc + 1) ? prev_start + FRM : cyc + 1;
                en_ok = 1'b1;
            end
            en_ok = en_ok & i_enable;
        end
        vprev = o_px_valid;
    end

    task automatic wr(input int a, input logic [23:0] d);
        i_wr_en = 1'b1; i_wr_addr = a[3:0]; i_wr_data = d;
        tick();
        i_wr_en = 1'b0;
    endtask

    task automatic commit();
        i_commit = 1'b1;
        tick();
        i_commit = 1'b0;
    endtask

    task automatic wait_start(output int at);
        at = -1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (o_frame_start) begin at = cyc; break; end
        end
        if (at < 0) tmo("frame_start_wait");
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (o_frame_done) begin at = cyc; break; end
        end
        if (at < 0) tmo("frame_done_wait");
    endtask

    function automatic logic [23:0] pat(input int i);
        logic [23:0] m;
        m = 24'(i + 1);
        return 24'h010203 * m;
    endfunction

    initial begin
        int s1, s2, s3, s4, s5, s6, s7, s8, d4, dd, k0, k;
        RESETN = 1'b0;
        repeat (3) tick();
        chk("rst_valid", o_px_valid, 1'b0);
        chk("rst_rgb", {o_px_r, o_px_g, o_px_b}, 24'h0);
        chk("rst_active", o_active_buf, 1'b0);
        chk("rst_err", o_err, 1'b0);
        RESETN = 1'b1;

        // Buffer 1 <- ramp, then swap in at the first frame
        for (int i = 0; i < N; i++) wr(i, pat(i));
        commit();
        i_enable = 1'b1;
        wait_start(s1);
        repeat (2) tick();
        // Back buffer 0 during frame 1: ramp with pixel 3 replaced
        for (int i = 0; i < N; i++) wr(i, (i == 3) ? 24'hFF0000 : pat(i));
        commit();
        wait_done(dd);
        chk("f1_px0", cap[0], 24'h010203);
        chk("f1_px3_old", cap[3], 24'h04080C);
        chk("f1_px9", cap[9], 24'h0A141E);
        chk("f1_active", o_active_buf, 1'b1);

        // Commit coincident with START keeps a swap pending for the next frame
        wait_start(s2);
        commit();
        chk("pace_f1_f2", s2 - s1, FRM);
        wait_done(dd);
        chk("f2_px3_new", cap[3], 24'hFF0000);
        chk("f2_active", o_active_buf, 1'b0);

        wait_start(s3);
        repeat (2) tick();
        wr(12, 24'h123456);
        wr(15, 24'hABCDEF);
        commit();
        wait_done(dd);
        chk("f3_px3", cap[3], 24'h04080C);
        chk("f3_active", o_active_buf, 1'b1);

        // Long busy makes frame 4 overrun the period
        wait_start(s4);
        chk("pace_f3_f4", s4 - s3, FRM);
        busy_len = 60;
        wait_done(d4);
        busy_len = 30;
        chk("f4_px3", cap[3], 24'hFF0000);
        chk("f4_px9", cap[9], 24'h0A141E);
        wait_start(s5);
        chk("overrun_restart", s5 - d4, 1);

        // Serializer silent for a whole frame
        ser_mode = 1'b0;
        wait_done(dd);
        chk("timeout_err", o_err, 1'b1);
        chk("timeout_strobes", last_cnt, N);
        ser_mode = 1'b1;

        // Enable dropped mid-frame: frame completes, then idle
        wait_start(s6);
        repeat (5) tick();
        i_enable = 1'b0;
        wait_done(dd);
        chk("disable_strobes", last_cnt, N);
        k0 = nstarts;
        repeat (800) tick();
        chk("idle_no_start", nstarts - k0, 0);

        // Reset during pixel 5
        i_enable = 1'b1;
        wait_start(s7);
        for (k = 0; k < 2000 && scount < 6; k++) tick();
        if (scount < 6) tmo("pixel5_wait");
        RESETN = 1'b0;
        tick();
        chk("midrst_zero", {o_px_valid, o_px_r, o_px_g, o_px_b, o_px_index,
                            o_active_buf, o_frame_start, o_frame_done, o_err}, '0);
        tick();
        RESETN = 1'b1;
        wait_start(s8);
        for (k = 0; k < 200 && !o_px_valid; k++) tick();
        if (!o_px_valid) tmo("first_strobe_wait");
        chk("restart_index", o_px_index, 4'd0);
        chk("restart_buf", o_active_buf, 1'b0);
        wait_done(dd);
        chk("restart_px3", cap[3], 24'hFF0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/neopixel_frame_scheduler.md
Name: neopixel_frame_scheduler

Overview:
Double-buffered frame controller that sits between the host-side pixel loader (UART byte assembler) and the writepixel WS2812 serializer. It holds two NUM_PIXELS x 24-bit pixel buffers. It streams the active buffer pixel-by-pixel through the serializer's valid/busy handshake, inserts the latch gap, and paces frames at a fixed period. Host writes always land in the back buffer, and buffers swap only at a frame boundary, so no frame is ever torn.

Parameters:
NUM_PIXELS, 10, pixels per chain (1..2^AW)
AW, 4, pixel address width
LATCH_CYCLES, 3600, low-time clocks after last pixel (300 us at 12 MHz)
FRAME_CYCLES, 200000, frame period in clocks, measured start-to-start
ACK_TIMEOUT, 8, max clocks from strobe to busy rising

Ports:
CLK  in  1  system clock
RESETN  in  1  synchronous active-low reset
i_enable  in  1  run frames; when low, finish current frame, then idle
i_wr_en  in  1  back-buffer write strobe
i_wr_addr  in  AW  pixel index
i_wr_data  in  24  {R[23:16], G[15:8], B[7:0]}
i_commit  in  1  request buffer swap at next frame start
i_px_busy  in  1  serializer busy
o_px_valid  out  1  one-cycle pixel strobe to serializer
o_px_r  out  8  red to serializer
o_px_g  out  8  green to serializer
o_px_b  out  8  blue to serializer
o_px_index  out  AW  index of pixel currently presented
o_active_buf  out  1  buffer being displayed
o_frame_start  out  1  one-cycle pulse, frame begins
o_frame_done  out  1  one-cycle pulse, latch gap complete
o_err  out  1  sticky: serializer ack timeout seen

Behaviour:
- Reset (RESETN=0 at a CLK edge): state IDLE; all outputs 0; commit-pending=0; period counter=0. Buffer RAM contents are not reset. Reset mid-pixel aborts immediately and o_px_valid drops the next cycle.
- Writes: on i_wr_en with i_wr_addr < NUM_PIXELS, write to buffer ~o_active_buf. Out-of-range addresses are ignored. A write in the swap cycle targets the pre-swap back buffer.
- Commit: i_commit sets pending. On a swap, o_active_buf toggles and pending clears. i_commit asserted in the swap cycle re-sets pending.
- Period counter: cleared at each frame start; otherwise increments and saturates at FRAME_CYCLES-1.
- FSM:
  - IDLE: if i_enable, go to START.
  - START: pulse o_frame_start; apply swap if pending; index=0; clear period counter; go to LOAD.
  - LOAD: synchronous RAM read of active[index], 1-cycle latency; go to STROBE.
  - STROBE: wait for i_px_busy=0. Register r/g/b and o_px_index, assert o_px_valid for exactly 1 cycle; go to WAIT_ACK.
  - WAIT_ACK: on busy=1, go to WAIT_DONE. After ACK_TIMEOUT clocks without busy, set o_err and treat the pixel as done.
  - WAIT_DONE: on busy=0, if index=NUM_PIXELS-1 go to LATCH; else index+1, go to LOAD.
  - LATCH: count LATCH_CYCLES with no strobe; then pulse o_frame_done and go to GAP.
  - GAP: if i_enable=0, go to IDLE. If period counter ≥ FRAME_CYCLES-1, go to START. Overrun frames (latch ends after the period) start next cycle.
- o_px_r/g/b hold their last value between strobes. Exactly NUM_PIXELS strobes are issued per frame.
- i_enable falling mid-frame does not truncate the frame.
- o_err clears only on reset.

Test Plan:
- Reset, write addr 0..9 = 0x010203*(i+1), commit, enable; serializer model busy 2 clk after valid for 30 clk -> 10 strobes carrying 0x010203..0x0A141E in order; o_active_buf=1; frame_done comes 3600 clk after last busy fall.
- Frame pacing: enable held -> frame_start pulses exactly 200000 clk apart. Lengthen busy so the frame exceeds 200000 -> next frame_start arrives the cycle after the GAP entry.
- Tear-free swap: during frame N, write addr 3=0xFF0000 and commit -> frame N still shows old pixel 3; frame N+1 shows 0xFF0000; commit coincident with START leaves pending=1.
- Out-of-range write addr 12 -> no buffer change; displayed data identical.
- Serializer never raises busy -> o_err=1 after 8 clk per pixel; frame still completes with 10 strobes.
- RESETN low during pixel 5 -> all outputs 0 next edge; after release with enable, the frame restarts at index 0 on buffer 0.
